// File: rtl/ripple_count_monitor.sv
// Synchronous reader for an asynchronous ripple up/down counter:
// synchronises, filters transients and checks every accepted step.
module ripple_count_monitor #(
  parameter int WIDTH      = 4,
  parameter int STABLE_CYC = 2,
  parameter int ERRW       = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic [WIDTH-1:0] q_in,
  input  logic             m,
  input  logic             err_clr,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_ref,
  output logic             step_up,
  output logic             step_down,
  output logic             wrap,
  output logic             err,
  output logic [ERRW-1:0]  err_cnt
);

  localparam int CW = $clog2(STABLE_CYC + 1);

  localparam logic [CW-1:0]    SMAX  = CW'(STABLE_CYC);
  localparam logic [CW-1:0]    CONE  = CW'(1);
  localparam logic [WIDTH-1:0] QONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] QMAX  = '1;
  localparam logic [ERRW-1:0]  EONE  = ERRW'(1);
  localparam logic [ERRW-1:0]  EMAX  = '1;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_TRACK = 1'b1;

  logic [WIDTH-1:0] q_s1_q;
  logic [WIDTH-1:0] q_s2_q;
  logic             m_s1_q;
  logic             m_s2_q;
  logic [1:0]       svld_q;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      q_s1_q <= '0;
      q_s2_q <= '0;
      m_s1_q <= 1'b0;
      m_s2_q <= 1'b0;
      svld_q <= '0;
    end else begin
      q_s1_q <= q_in;
      q_s2_q <= q_s1_q;
      m_s1_q <= m;
      m_s2_q <= m_s1_q;
      svld_q <= {svld_q[0], 1'b1};
    end
  end

  // cnt==0 marks an empty candidate so the cleared
  // sync flops never count as real samples.
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             stable;

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (svld_q[1]) begin
      if (cnt_q == '0 || q_s2_q != cand_q) begin
        cand_d = q_s2_q;
        cnt_d  = CONE;
      end else if (cnt_q < SMAX) begin
        cnt_d = cnt_q + CONE;
      end
    end
  end

  assign stable = (cnt_q == SMAX);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic             vld_q, vld_d;
  logic             up_q, up_d;
  logic             dn_q, dn_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             is_up, is_dn;

  assign is_up = (cand_q == ref_q + QONE) &&  m_s2_q;
  assign is_dn = (cand_q == ref_q - QONE) && !m_s2_q;

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    vld_d   = vld_q;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (stable) begin
      unique case (state_q)
        ST_INIT: begin
          ref_d   = cand_q;
          vld_d   = 1'b1;
          state_d = ST_TRACK;
        end
        ST_TRACK: begin
          if (cand_q != ref_q) begin
            ref_d = cand_q;
            unique case (1'b1)
              is_up: begin
                up_d   = 1'b1;
                wrap_d = (ref_q == QMAX);
              end
              is_dn: begin
                dn_d   = 1'b1;
                wrap_d = (ref_q == '0);
              end
              default: err_d = 1'b1;
            endcase
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  logic [ERRW-1:0] ecnt_q, ecnt_d;

  always_comb begin
    ecnt_d = ecnt_q;
    if (err_clr) begin
      ecnt_d = err_d ? EONE : '0;
    end else if (err_d && ecnt_q != EMAX) begin
      ecnt_d = ecnt_q + EONE;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= ST_INIT;
      ref_q   <= '0;
      vld_q   <= 1'b0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      vld_q   <= vld_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign q_valid   = vld_q;
  assign q_ref     = ref_q;
  assign step_up   = up_q;
  assign step_down = dn_q;
  assign wrap      = wrap_q;
  assign err       = err_q;
  assign err_cnt   = ecnt_q;

endmodule
